// File: rtl/vfifo_pkg.sv
// Shared definitions for the vfifo controllers: depth helpers and the
// status-flag bundle whose bit order is reused by the dual-clock variant.
package vfifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  function automatic int vfifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Bit order {overflow, underflow, almost_full, almost_empty, full, empty}.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic almost_full;
    logic almost_empty;
    logic full;
    logic empty;
  } vfifo_status_t;

  // An empty FIFO is also almost empty; nothing else is asserted.
  localparam vfifo_status_t VFIFO_STATUS_RST = 6'b000101;

endpackage

// File: rtl/vfifo_sc_ctrl_if.sv
// Request/status bundle between the FIFO controller (slave side) and the
// producer/consumer logic that owns the RAM data path (master side).
interface vfifo_sc_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  import vfifo_pkg::*;

  logic                  wr_req;
  logic                  rd_req;
  logic                  clear;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] adr_a;
  logic [ADDR_WIDTH-1:0] adr_b;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fill_level;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr_req, rd_req, clear,
    output we_a, adr_a, adr_b, rd_valid, full, empty,
           almost_full, almost_empty, fill_level, overflow, underflow
  );

  modport master (
    output wr_req, rd_req, clear,
    input  we_a, adr_a, adr_b, rd_valid, full, empty,
           almost_full, almost_empty, fill_level, overflow, underflow
  );

endinterface

// File: rtl/vfifo_ptr.sv
// Wrapping FIFO pointer with one extra MSB so full and empty can be told
// apart when the address bits match.
module vfifo_ptr
  import vfifo_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o,
  output logic [W-1:0] ptr_d_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Clear wins over increment; the add wraps naturally at 2**W.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign ptr_d_o = ptr_d;

endmodule

// File: rtl/vfifo_sc_ctrl.sv
// Single-clock FIFO controller: owns the read/write pointers of an external
// dual-port RAM, gates requests on registered flags and reports fill status.
module vfifo_sc_ctrl
  import vfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int AFULL_TH   = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  vfifo_sc_ctrl_if.slave bus
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = vfifo_depth(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_TH);
  localparam logic [PTR_W-1:0] DEPTH_LVL  = PTR_W'(DEPTH);

  logic             wr_acc;
  logic             rd_acc;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] fill_q;
  logic [PTR_W-1:0] fill_d;
  logic             rd_valid_q;
  logic             rd_valid_d;
  vfifo_status_t    stat_q;
  vfifo_status_t    stat_d;

  // Acceptance looks only at last cycle's flags, so no combinational path
  // runs from a request through the pointers back into the flags.
  always_comb begin
    wr_acc = bus.wr_req & ~stat_q.full  & ~bus.clear;
    rd_acc = bus.rd_req & ~stat_q.empty & ~bus.clear;
  end

  vfifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (wr_acc),
    .clr_i   (bus.clear),
    .ptr_o   (wr_ptr_q),
    .ptr_d_o (wr_ptr_d)
  );

  vfifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (rd_acc),
    .clr_i   (bus.clear),
    .ptr_o   (rd_ptr_q),
    .ptr_d_o (rd_ptr_d)
  );

  // Fill level is tracked incrementally and always equals wr_ptr - rd_ptr.
  always_comb begin
    fill_d = fill_q;
    if (bus.clear) begin
      fill_d = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   fill_d = fill_q + PTR_W'(1);
        2'b01:   fill_d = fill_q - PTR_W'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Full is equal address bits with opposite MSBs on the next pointers.
  always_comb begin
    stat_d              = VFIFO_STATUS_RST;
    stat_d.empty        = (wr_ptr_d == rd_ptr_d);
    stat_d.full         = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0])
                          && (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    stat_d.almost_full  = (fill_d >= AFULL_LVL);
    stat_d.almost_empty = (fill_d <= AEMPTY_LVL);
    stat_d.overflow     = bus.wr_req & stat_q.full  & ~bus.clear;
    stat_d.underflow    = bus.rd_req & stat_q.empty & ~bus.clear;
    rd_valid_d          = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      stat_q     <= VFIFO_STATUS_RST;
      rd_valid_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      stat_q     <= stat_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.we_a         = wr_acc;
  assign bus.adr_a        = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.adr_b        = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.rd_valid     = rd_valid_q;
  assign bus.fill_level   = fill_q;
  assign bus.full         = stat_q.full;
  assign bus.empty        = stat_q.empty;
  assign bus.almost_full  = stat_q.almost_full;
  assign bus.almost_empty = stat_q.almost_empty;
  assign bus.overflow     = stat_q.overflow;
  assign bus.underflow    = stat_q.underflow;

  // DEPTH_LVL documents the largest legal fill_level value.
  logic unused_depth;
  assign unused_depth = ^DEPTH_LVL;

endmodule

// File: tb/tb_vfifo_sc_ctrl.sv
// Randomised bench for vfifo_sc_ctrl: a queue-based FIFO model plus a small
// behavioural RAM check addressing, flags, pulses and read-data alignment.
module tb_vfifo_sc_ctrl;

  localparam int AW     = 9;
  localparam int DEPTH  = 1 << AW;
  localparam int AFULL  = DEPTH - 4;
  localparam int AEMPTY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vfifo_sc_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  vfifo_sc_ctrl #(
    .ADDR_WIDTH (AW),
    .AFULL_TH   (AFULL),
    .AEMPTY_TH  (AEMPTY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the dual-port RAM the parent wrapper owns.
  logic [15:0] mem [DEPTH];
  logic [15:0] qB;
  logic [15:0] dataIn;

  always @(posedge clk) begin
    if (bus.we_a) mem[bus.adr_a] <= dataIn;
    qB <= mem[bus.adr_b];
  end

  int testCount = 0;
  int failCount = 0;

  logic [15:0] dataQ[$];
  int          wrAddr;
  int          rdAddr;
  bit          expRdValid;
  bit          expOvf;
  bit          expUnf;
  logic [15:0] expData;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time,
               observed, expected);
    end
  endtask

  task automatic modelReset();
    dataQ.delete();
    wrAddr     = 0;
    rdAddr     = 0;
    expRdValid = 1'b0;
    expOvf     = 1'b0;
    expUnf     = 1'b0;
  endtask

  task automatic checkRegs();
    int fill;
    fill = dataQ.size();
    checkOutput("fill_level",   32'(bus.fill_level),   32'(fill));
    checkOutput("empty",        32'(bus.empty),        32'(fill == 0));
    checkOutput("full",         32'(bus.full),         32'(fill == DEPTH));
    checkOutput("almost_empty", 32'(bus.almost_empty), 32'(fill <= AEMPTY));
    checkOutput("almost_full",  32'(bus.almost_full),  32'(fill >= AFULL));
    checkOutput("rd_valid",     32'(bus.rd_valid),     32'(expRdValid));
    checkOutput("overflow",     32'(bus.overflow),     32'(expOvf));
    checkOutput("underflow",    32'(bus.underflow),    32'(expUnf));
    if (expRdValid) checkOutput("q_b", 32'(qB), 32'(expData));
  endtask

  // One clock cycle: check last edge's results, drive new requests, check
  // the combinational RAM controls, then advance the model over the edge.
  task automatic applyStimulus(input bit wr, input bit rd, input bit clr);
    bit isFull;
    bit isEmpty;
    bit wrAcc;
    bit rdAcc;
    @(negedge clk);
    checkRegs();
    bus.wr_req = wr;
    bus.rd_req = rd;
    bus.clear  = clr;
    dataIn     = 16'($urandom);
    isFull  = (dataQ.size() == DEPTH);
    isEmpty = (dataQ.size() == 0);
    wrAcc   = wr && !isFull && !clr;
    rdAcc   = rd && !isEmpty && !clr;
    #1;
    checkOutput("we_a",  32'(bus.we_a),  32'(wrAcc));
    checkOutput("adr_a", 32'(bus.adr_a), 32'(wrAddr));
    checkOutput("adr_b", 32'(bus.adr_b), 32'(rdAddr));
    @(posedge clk);
    expOvf     = wr && isFull && !clr;
    expUnf     = rd && isEmpty && !clr;
    expRdValid = rdAcc;
    if (rdAcc) begin
      expData = dataQ.pop_front();
      rdAddr  = (rdAddr + 1) % DEPTH;
    end
    if (wrAcc) begin
      dataQ.push_back(dataIn);
      wrAddr = (wrAddr + 1) % DEPTH;
    end
    if (clr) begin
      dataQ.delete();
      wrAddr = 0;
      rdAddr = 0;
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst fill_level",   32'(bus.fill_level),   32'd0);
    checkOutput("rst empty",        32'(bus.empty),        32'd1);
    checkOutput("rst almost_empty", 32'(bus.almost_empty), 32'd1);
    checkOutput("rst full",         32'(bus.full),         32'd0);
    checkOutput("rst almost_full",  32'(bus.almost_full),  32'd0);
    checkOutput("rst rd_valid",     32'(bus.rd_valid),     32'd0);
    checkOutput("rst overflow",     32'(bus.overflow),     32'd0);
    checkOutput("rst underflow",    32'(bus.underflow),    32'd0);
    checkOutput("rst adr_a",        32'(bus.adr_a),        32'd0);
    checkOutput("rst adr_b",        32'(bus.adr_b),        32'd0);
    checkOutput("rst we_a",         32'(bus.we_a),         32'd0);
  endtask

  // Asserts rst_n between clock edges so the reset is seen asynchronously.
  task automatic midReset();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.clear  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int wrPct;
    int rdPct;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.clear  = 1'b0;
    dataIn     = '0;
    modelReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;

    // Three writes, three reads, then let rd_valid and flags settle.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    // Underflow on empty, then write+read on empty, then the delayed read.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    // Fill to the brim, overflow twice, then simultaneous access while full.
    repeat (DEPTH) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2 && dataQ.size() > 0; i++)
      applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Long stream at level 5 wraps both pointers; clear lands mid-stream.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (1500) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    // Random traffic, biased per segment to visit full, empty and between.
    for (int seg = 0; seg < 3; seg++) begin
      wrPct = (seg == 0) ? 90 : (seg == 1) ? 10 : 50;
      rdPct = 100 - wrPct;
      for (int i = 0; i < 1000; i++) begin
        applyStimulus($urandom_range(0, 99) < wrPct,
                      $urandom_range(0, 99) < rdPct,
                      $urandom_range(0, 499) == 0);
      end
    end

    // Asynchronous reset with a read in flight.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    midReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
